// File: rtl/dcm_pkg.sv
// -----------------------------------------------------------------------------
// dcm_pkg
// Definitions shared by the DCM programming controller and the dcm clock
// generator: FSM state encoding, the legal mode range, and the saturating
// mode step helper.
// Ports: none (package).
// -----------------------------------------------------------------------------
package dcm_pkg;

    typedef logic [2:0] mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam mode_t MODE_MIN = 3'd0;
    localparam mode_t MODE_MAX = 3'd7;

    // One step up or down, clamped to [MODE_MIN, MODE_MAX] so it never wraps.
    function automatic mode_t mode_step(input mode_t m, input logic up);
        mode_t r_res;
        if (up) begin
            r_res = (m == MODE_MAX) ? MODE_MAX : m + 3'd1;
        end else begin
            r_res = (m == MODE_MIN) ? MODE_MIN : m - 3'd1;
        end
        return r_res;
    endfunction

endpackage

// File: rtl/dcm_prog_ctrl_if.sv
// -----------------------------------------------------------------------------
// dcm_prog_ctrl_if
// Bundles the button inputs, the dcm programming handshake and the status
// outputs of dcm_prog_ctrl.
//   btn_up / btn_down : raw button levels (master -> slave)
//   prog_out          : mode currently generated by dcm (master -> slave)
//   update, prog_in   : request strobe and requested mode (slave -> master)
//   busy, err, mode   : status (slave -> master)
// The controller uses the slave modport; the environment drives master.
// -----------------------------------------------------------------------------
interface dcm_prog_ctrl_if;
    import dcm_pkg::*;

    logic  btn_up;
    logic  btn_down;
    mode_t prog_out;
    logic  update;
    mode_t prog_in;
    logic  busy;
    logic  err;
    mode_t mode;

    modport master (
        output btn_up, btn_down, prog_out,
        input  update, prog_in, busy, err, mode
    );

    modport slave (
        input  btn_up, btn_down, prog_out,
        output update, prog_in, busy, err, mode
    );
endinterface

// File: rtl/edge_detector.sv
// -----------------------------------------------------------------------------
// edge_detector
// Registered rising-edge detector for a level already synchronous to clock.
//   clock  : clock
//   reset  : asynchronous reset, active-high
//   din    : input level
//   rising : one-cycle pulse in the cycle after din is first sampled high
// -----------------------------------------------------------------------------
module edge_detector (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic rising
);
    logic r_prev;
    logic r_rising;

    // Remember the last sampled level and register the 0->1 transition.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_prev   <= 1'b0;
            r_rising <= 1'b0;
        end else begin
            r_prev   <= din;
            r_rising <= din & ~r_prev;
        end
    end

    assign rising = r_rising;
endmodule

// File: rtl/dcm_prog_ctrl.sv
// -----------------------------------------------------------------------------
// dcm_prog_ctrl
// Turns up/down button presses into a saturating target mode (0..7), holds
// update high for UPD_CYCLES cycles with prog_in = target, then waits up to
// TIMEOUT cycles for the dcm to report the new mode on prog_out. A missing
// confirmation sets the sticky err flag and reverts the target.
//   clk : 100 MHz system clock
//   rst : asynchronous reset, active-high
//   bus : dcm_prog_ctrl_if.slave (buttons, prog_out in; update, prog_in,
//         busy, err, mode out; all outputs registered)
// -----------------------------------------------------------------------------
module dcm_prog_ctrl
    import dcm_pkg::*;
#(
    parameter int UPD_CYCLES = 4,
    parameter int TIMEOUT    = 1000
) (
    input  logic            clk,
    input  logic            rst,
    dcm_prog_ctrl_if.slave  bus
);
    localparam logic [31:0] UPD_LAST = 32'(UPD_CYCLES - 1);
    localparam logic [31:0] TO_LAST  = 32'(TIMEOUT - 1);

    logic w_rise_up;
    logic w_rise_dn;
    logic w_up_only;
    logic w_dn_only;
    logic w_any_pulse;

    state_t      r_state;
    mode_t       r_tgt;
    mode_t       r_mode;
    logic [31:0] r_cnt;
    logic        r_update;
    logic        r_busy;
    logic        r_err;

    edge_detector u_edge_up (
        .clock  (clk),
        .reset  (rst),
        .din    (bus.btn_up),
        .rising (w_rise_up)
    );

    edge_detector u_edge_dn (
        .clock  (clk),
        .reset  (rst),
        .din    (bus.btn_down),
        .rising (w_rise_dn)
    );

    // Simultaneous up and down cancel each other, but still block a resync.
    assign w_up_only   = w_rise_up & ~w_rise_dn;
    assign w_dn_only   = w_rise_dn & ~w_rise_up;
    assign w_any_pulse = w_rise_up | w_rise_dn;

    // Request FSM: IDLE accepts presses, PULSE drives update, WAIT confirms.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_tgt    <= MODE_MIN;
            r_mode   <= MODE_MIN;
            r_cnt    <= 32'd0;
            r_update <= 1'b0;
            r_busy   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_up_only && (r_tgt != MODE_MAX)) begin
                        r_tgt    <= mode_step(r_tgt, 1'b1);
                        r_state  <= PULSE;
                        r_update <= 1'b1;
                        r_busy   <= 1'b1;
                        r_cnt    <= 32'd0;
                    end else if (w_dn_only && (r_tgt != MODE_MIN)) begin
                        r_tgt    <= mode_step(r_tgt, 1'b0);
                        r_state  <= PULSE;
                        r_update <= 1'b1;
                        r_busy   <= 1'b1;
                        r_cnt    <= 32'd0;
                    end else if (!w_any_pulse && (bus.prog_out != r_mode)) begin
                        // Someone else reprogrammed the dcm: follow it.
                        r_mode <= bus.prog_out;
                        r_tgt  <= bus.prog_out;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                PULSE: begin
                    if (r_cnt == UPD_LAST) begin
                        r_state  <= WAIT;
                        r_update <= 1'b0;
                        r_cnt    <= 32'd0;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                WAIT: begin
                    if (bus.prog_out == r_tgt) begin
                        r_mode  <= r_tgt;
                        r_err   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                        r_cnt   <= 32'd0;
                    end else if (r_cnt == TO_LAST) begin
                        // No confirmation: flag it and fall back to the old mode.
                        r_err   <= 1'b1;
                        r_tgt   <= r_mode;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                        r_cnt   <= 32'd0;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_update <= 1'b0;
                    r_busy   <= 1'b0;
                    r_cnt    <= 32'd0;
                end
            endcase
        end
    end

    // prog_in is the target register itself, so it always equals tgt.
    assign bus.update  = r_update;
    assign bus.prog_in = r_tgt;
    assign bus.busy    = r_busy;
    assign bus.err     = r_err;
    assign bus.mode    = r_mode;
endmodule

// File: tb/tb_dcm_prog_ctrl.sv
module tb_dcm_prog_ctrl;
    import dcm_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    dcm_prog_ctrl_if bus_if ();

    dcm_prog_ctrl #(
        .UPD_CYCLES (4),
        .TIMEOUT    (16)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic  up;
        logic  dn;
        mode_t po;
        logic  upd;
        mode_t pi;
        logic  busy;
        logic  err;
        mode_t mode;
    } vec_t;

    vec_t vecs [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] outs_now();
        return {23'd0, bus_if.update, bus_if.prog_in, bus_if.busy, bus_if.err, bus_if.mode};
    endfunction

    // Press a button, answer on prog_out with 'reply', count update cycles.
    task automatic request(input logic up, input logic dn, input mode_t reply,
                           input int exp_pulses, input mode_t exp_mode, input string name);
        int n_upd;
        n_upd = 0;
        bus_if.btn_up   = up;
        bus_if.btn_down = dn;
        tick();
        bus_if.btn_up   = 1'b0;
        bus_if.btn_down = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (bus_if.update === 1'b1) n_upd++;
            if (c == 3) bus_if.prog_out = reply;
        end
        check({name, "_upd"},  32'(n_upd), 32'(exp_pulses));
        check({name, "_mode"}, {29'd0, bus_if.mode}, {29'd0, exp_mode});
        check({name, "_busy"}, {31'd0, bus_if.busy}, 32'd0);
    endtask

    initial begin
        int busy_cyc;
        int n_upd;
        int bad_pi;

        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus_if.btn_up   = 1'b0;
        bus_if.btn_down = 1'b0;
        bus_if.prog_out = 3'd0;

        //            up    dn    po    upd   pi    busy  err   mode
        vecs[0] = '{1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0};
        vecs[1] = '{1'b0, 1'b0, 3'd0, 1'b1, 3'd1, 1'b1, 1'b0, 3'd0};
        vecs[2] = '{1'b0, 1'b0, 3'd0, 1'b1, 3'd1, 1'b1, 1'b0, 3'd0};
        vecs[3] = '{1'b0, 1'b0, 3'd0, 1'b1, 3'd1, 1'b1, 1'b0, 3'd0};
        vecs[4] = '{1'b0, 1'b0, 3'd0, 1'b1, 3'd1, 1'b1, 1'b0, 3'd0};
        vecs[5] = '{1'b0, 1'b0, 3'd1, 1'b0, 3'd1, 1'b1, 1'b0, 3'd0};
        vecs[6] = '{1'b0, 1'b0, 3'd1, 1'b0, 3'd1, 1'b0, 1'b0, 3'd1};
        vecs[7] = '{1'b0, 1'b0, 3'd1, 1'b0, 3'd1, 1'b0, 1'b0, 3'd1};

        tick();
        tick();
        check("reset_outputs", outs_now(), 32'd0);
        rst = 1'b0;

        // Single up press, dcm confirms three cycles after prog_in changes.
        foreach (vecs[i]) begin
            bus_if.btn_up   = vecs[i].up;
            bus_if.btn_down = vecs[i].dn;
            bus_if.prog_out = vecs[i].po;
            tick();
            check($sformatf("vec%0d", i), outs_now(),
                  {23'd0, vecs[i].upd, vecs[i].pi, vecs[i].busy, vecs[i].err, vecs[i].mode});
        end
        bus_if.btn_up = 1'b0;

        // Climb to 7, then the eighth press saturates.
        for (int m = 2; m <= 7; m++) begin
            request(1'b1, 1'b0, 3'(m), 4, 3'(m), $sformatf("up_to%0d", m));
        end
        request(1'b1, 1'b0, 3'd7, 0, 3'd7, "up_sat");

        // Down from 0 also saturates.
        rst = 1'b1;
        tick();
        bus_if.prog_out = 3'd0;
        rst = 1'b0;
        tick();
        request(1'b0, 1'b1, 3'd0, 0, 3'd0, "dn_sat");

        // Timeout: prog_out stuck at 0.
        bus_if.btn_up = 1'b1;
        tick();
        bus_if.btn_up = 1'b0;
        busy_cyc = 0;
        n_upd    = 0;
        for (int c = 0; c < 60; c++) begin
            tick();
            if (bus_if.update === 1'b1) n_upd++;
            if (bus_if.busy === 1'b1) busy_cyc++;
            else if (busy_cyc > 0) break;
        end
        check("to_busy_cycles", 32'(busy_cyc), 32'd20);
        check("to_upd_cycles",  32'(n_upd),    32'd4);
        check("to_err",     {31'd0, bus_if.err},     32'd1);
        check("to_prog_in", {29'd0, bus_if.prog_in}, 32'd0);
        check("to_mode",    {29'd0, bus_if.mode},    32'd0);

        // A successful request clears err.
        request(1'b1, 1'b0, 3'd1, 4, 3'd1, "clr");
        check("clr_err", {31'd0, bus_if.err}, 32'd0);

        // Both buttons in the same cycle: ignored.
        request(1'b1, 1'b1, 3'd1, 0, 3'd1, "both");
        check("both_prog_in", {29'd0, bus_if.prog_in}, 32'd1);

        // Presses during WAIT are dropped.
        bus_if.btn_up = 1'b1;
        tick();
        bus_if.btn_up = 1'b0;
        n_upd  = 0;
        bad_pi = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (bus_if.update === 1'b1) n_upd++;
            if ((bus_if.busy === 1'b1) && (bus_if.prog_in !== 3'd2)) bad_pi++;
            case (c)
                6:       bus_if.btn_up   = 1'b1;
                7:       bus_if.btn_up   = 1'b0;
                8:       bus_if.btn_down = 1'b1;
                9:       bus_if.btn_down = 1'b0;
                14:      bus_if.prog_out = 3'd2;
                default: ;
            endcase
        end
        check("drop_upd",    32'(n_upd),  32'd4);
        check("drop_pi_bad", 32'(bad_pi), 32'd0);
        check("drop_state", outs_now(), {23'd0, 1'b0, 3'd2, 1'b0, 1'b0, 3'd2});

        // Reset in the middle of PULSE drops update before the next edge.
        bus_if.btn_up = 1'b1;
        tick();
        bus_if.btn_up = 1'b0;
        tick();
        tick();
        check("pulse_active", {31'd0, bus_if.update}, 32'd1);
        #3;
        rst = 1'b1;
        #1;
        check("async_reset", outs_now(), 32'd0);
        bus_if.prog_out = 3'd0;
        #1;
        rst = 1'b0;
        tick();
        check("post_reset", outs_now(), 32'd0);

        // External change of prog_out in IDLE is adopted one cycle later.
        bus_if.prog_out = 3'd5;
        tick();
        check("resync_mode", outs_now(), {23'd0, 1'b0, 3'd5, 1'b0, 1'b0, 3'd5});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
